seq_det_param: RTL and testbench

SEQ_DET_PARAM -- requirements
Module: seq_det_param

---
 rtl/seq_det_pkg.sv | 13 +
 rtl/seq_det_sat_cnt.sv | 31 +++
 rtl/seq_det_param.sv | 87 ++++++++
 tb/tb_seq_det_param.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared state type and default sizing for the parameterised serial sequence detector.
package seq_det_pkg;

    localparam int SEQ_LEN_DEF = 4;
    localparam int CNT_W_DEF   = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_RUN  = 2'd2
    } state_e;

endpackage

// File: rtl/seq_det_sat_cnt.sv
// Saturating match counter with synchronous clear; only built when SEQ_DET_CNT_EN is defined.
`ifdef SEQ_DET_CNT_EN
module seq_det_sat_cnt
    import seq_det_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_inc,
    input  logic             i_clear,
    output logic [CNT_W-1:0] o_count
);

    logic [CNT_W-1:0] r_count;

    // Clear wins over a coincident increment; the count sticks at all-ones.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count != {CNT_W{1'b1}})) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_count = r_count;

endmodule
`endif

// File: rtl/seq_det_param.sv
// Serial pattern detector with loadable pattern and overlap control.
// Optional match counter enabled by defining SEQ_DET_CNT_EN; otherwise match_cnt reads 0.
module seq_det_param
    import seq_det_pkg::*;
#(
    parameter int SEQ_LEN = SEQ_LEN_DEF,
    parameter int CNT_W   = CNT_W_DEF
) (
    input  logic               clk,
    input  logic               clr,
    input  logic               E,
    input  logic               E_valid,
    input  logic [SEQ_LEN-1:0] user_seq,
    input  logic               load,
    input  logic               overlap,
    input  logic               cnt_clr,
    output logic               Y,
    output logic [CNT_W-1:0]   match_cnt
);

    localparam int                FILL_W = $clog2(SEQ_LEN + 1);
    localparam logic [FILL_W-1:0] FULL   = FILL_W'(SEQ_LEN);

    state_e              r_state;
    logic [SEQ_LEN-1:0]  r_pattern;
    logic [SEQ_LEN-1:0]  r_hist;
    logic [FILL_W-1:0]   r_fill;
    logic                r_y;

    logic [SEQ_LEN-1:0]  w_hist_next;
    logic [FILL_W-1:0]   w_fill_next;
    logic                w_sample;
    logic                w_match;

    assign w_sample    = E_valid && !load && (r_state != S_IDLE);
    assign w_hist_next = (r_hist << 1) | SEQ_LEN'(E);
    assign w_fill_next = (r_fill == FULL) ? r_fill : r_fill + FILL_W'(1);
    assign w_match     = w_sample && (w_fill_next == FULL) && (w_hist_next == r_pattern);

    // A non-overlapping match restarts the fill so the next match needs SEQ_LEN fresh bits.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state   <= S_IDLE;
            r_pattern <= '0;
            r_hist    <= '0;
            r_fill    <= '0;
            r_y       <= 1'b0;
        end else begin
            r_y <= w_match;
            if (load) begin
                r_pattern <= user_seq;
                r_hist    <= '0;
                r_fill    <= '0;
                r_state   <= S_FILL;
            end else if (w_sample) begin
                if (w_match && !overlap) begin
                    r_hist  <= '0;
                    r_fill  <= '0;
                    r_state <= S_FILL;
                end else begin
                    r_hist  <= w_hist_next;
                    r_fill  <= w_fill_next;
                    r_state <= (w_fill_next == FULL) ? S_RUN : S_FILL;
                end
            end
        end
    end

    assign Y = r_y;

`ifdef SEQ_DET_CNT_EN
    seq_det_sat_cnt #(
        .CNT_W(CNT_W)
    ) u_sat_cnt (
        .i_clk  (clk),
        .i_rst_n(clr),
        .i_inc  (w_match),
        .i_clear(cnt_clr),
        .o_count(match_cnt)
    );
`else
    logic w_unused_cnt_clr;
    assign w_unused_cnt_clr = cnt_clr;
    assign match_cnt        = '0;
`endif

endmodule

// File: tb/tb_seq_det_param.sv
// Self-checking bench for seq_det_param: directed scenarios plus random traffic on two
// instances (SEQ_LEN=4/CNT_W=8 and SEQ_LEN=2/CNT_W=2) against a bit-stream reference model.
module tb_seq_det_param;

`ifdef SEQ_DET_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       clrN;
    logic       e4, ev4, ld4, ov4, cc4, y4;
    logic [3:0] seq4;
    logic [7:0] cnt4;
    logic       e2, ev2, ld2, ov2, cc2, y2;
    logic [1:0] seq2;
    logic [1:0] cnt2;

    int checks = 0;
    int errors = 0;

    // Reference model: history kept as an integer of the last mLen bits plus a bit count.
    int mLen[2] = '{4, 2};
    int mMax[2] = '{255, 3};
    int mPat[2], mHist[2], mFill[2], mCnt[2], mY[2];
    bit mLoaded[2];
    int yCount[2];

    seq_det_param #(.SEQ_LEN(4), .CNT_W(8)) dut4 (
        .clk(clock), .clr(clrN), .E(e4), .E_valid(ev4), .user_seq(seq4), .load(ld4),
        .overlap(ov4), .cnt_clr(cc4), .Y(y4), .match_cnt(cnt4)
    );

    seq_det_param #(.SEQ_LEN(2), .CNT_W(2)) dut2 (
        .clk(clock), .clr(clrN), .E(e2), .E_valid(ev2), .user_seq(seq2), .load(ld2),
        .overlap(ov2), .cnt_clr(cc2), .Y(y2), .match_cnt(cnt2)
    );

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed %0d expected %0d", tag, $time, observed, expected);
        end
    endtask

    task automatic modelReset();
        for (int d = 0; d < 2; d++) begin
            mPat[d] = 0; mHist[d] = 0; mFill[d] = 0; mCnt[d] = 0; mY[d] = 0; mLoaded[d] = 1'b0;
        end
    endtask

    task automatic modelStep(input int d, input bit ld, input bit ev, input bit e,
                             input int useq, input bit ov, input bit cc);
        bit hit = 1'b0;
        if (ld) begin
            mPat[d] = useq; mHist[d] = 0; mFill[d] = 0; mLoaded[d] = 1'b1;
        end else if (ev && mLoaded[d]) begin
            mHist[d] = (mHist[d] * 2 + int'(e)) % (1 << mLen[d]);
            if (mFill[d] < mLen[d]) mFill[d]++;
            if (mFill[d] == mLen[d] && mHist[d] == mPat[d]) begin
                hit = 1'b1;
                if (!ov) begin
                    mFill[d] = 0; mHist[d] = 0;
                end
            end
        end
        mY[d] = int'(hit);
        if (CNT_EN) begin
            if (cc) mCnt[d] = 0;
            else if (hit && mCnt[d] < mMax[d]) mCnt[d]++;
        end
    endtask

    task automatic tick();
        @(posedge clock);
        modelStep(0, ld4, ev4, e4, int'(seq4), ov4, cc4);
        modelStep(1, ld2, ev2, e2, int'(seq2), ov2, cc2);
        #1;
        checkOutput("y4", int'(y4), mY[0]);
        checkOutput("cnt4", int'(cnt4), mCnt[0]);
        checkOutput("y2", int'(y2), mY[1]);
        checkOutput("cnt2", int'(cnt2), mCnt[1]);
        yCount[0] += int'(y4);
        yCount[1] += int'(y2);
    endtask

    task automatic idleAll();
        e4 = 1'b0; ev4 = 1'b0; ld4 = 1'b0; ov4 = 1'b0; cc4 = 1'b0; seq4 = '0;
        e2 = 1'b0; ev2 = 1'b0; ld2 = 1'b0; ov2 = 1'b0; cc2 = 1'b0; seq2 = '0;
    endtask

    task automatic applyStimulus(input int d, input bit ld, input bit ev, input bit e,
                                 input int useq, input bit ov, input bit cc);
        if (d == 0) begin
            ld4 = ld; ev4 = ev; e4 = e; seq4 = 4'(useq); ov4 = ov; cc4 = cc;
        end else begin
            ld2 = ld; ev2 = ev; e2 = e; seq2 = 2'(useq); ov2 = ov; cc2 = cc;
        end
    endtask

    task automatic step(input int d, input bit ld, input bit ev, input bit e,
                        input int useq, input bit ov, input bit cc);
        idleAll();
        applyStimulus(d, ld, ev, e, useq, ov, cc);
        tick();
    endtask

    // Called just after a clock edge: pulses clr low between edges and checks outputs at once.
    task automatic resetAsync(input string tag);
        idleAll();
        #3;
        clrN = 1'b0;
        #1;
        modelReset();
        checkOutput({tag, "_y4"}, int'(y4), 0);
        checkOutput({tag, "_cnt4"}, int'(cnt4), 0);
        checkOutput({tag, "_y2"}, int'(y2), 0);
        checkOutput({tag, "_cnt2"}, int'(cnt2), 0);
        #2;
        clrN = 1'b1;
        yCount[0] = 0;
        yCount[1] = 0;
    endtask

    initial begin
        int s7[7] = '{1, 0, 0, 1, 0, 0, 1};
        int s4[4] = '{0, 1, 1, 0};
        int exp36[6] = '{0, 1, 2, 3, 3, 3};

        clrN = 1'b0;
        idleAll();
        modelReset();
        yCount[0] = 0;
        yCount[1] = 0;
        #12;
        checkOutput("rst_y4", int'(y4), 0);
        checkOutput("rst_cnt4", int'(cnt4), 0);
        @(negedge clock);
        clrN = 1'b1;

        // Idle after reset: no pattern loaded, bits must be ignored.
        for (int i = 0; i < 6; i++) step(0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("idle_pulses", yCount[0], 0);

        $display("[TB] overlap stream 1001001");
        step(0, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1'b0);
        foreach (s7[i]) step(0, 1'b0, 1'b1, 1'(s7[i]), 0, 1'b1, 1'b0);
        checkOutput("ovl_pulses", yCount[0], 2);
        checkOutput("ovl_cnt", int'(cnt4), CNT_EN ? 2 : 0);

        resetAsync("r1");
        $display("[TB] non-overlap stream 1001001");
        step(0, 1'b1, 1'b0, 1'b0, 9, 1'b0, 1'b0);
        foreach (s7[i]) step(0, 1'b0, 1'b1, 1'(s7[i]), 0, 1'b0, 1'b0);
        checkOutput("novl_pulses", yCount[0], 1);
        checkOutput("novl_cnt", int'(cnt4), CNT_EN ? 1 : 0);

        resetAsync("r2");
        $display("[TB] valid gap inside pattern");
        step(0, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(0, 1'b0, 1'b0, 1'(i % 2), 0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        checkOutput("gap_y", int'(y4), 1);
        step(0, 1'b0, 1'b0, 1'b0, 0, 1'b1, 1'b0);
        checkOutput("gap_pulses", yCount[0], 1);

        resetAsync("r3");
        $display("[TB] reload mid-fill");
        step(0, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
        step(0, 1'b0, 1'b1, 1'b0, 0, 1'b1, 1'b0);
        step(0, 1'b1, 1'b1, 1'b1, 6, 1'b1, 1'b0);
        foreach (s4[i]) step(0, 1'b0, 1'b1, 1'(s4[i]), 0, 1'b1, 1'b0);
        checkOutput("reload_y", int'(y4), 1);
        checkOutput("reload_pulses", yCount[0], 1);

        resetAsync("r4");
        $display("[TB] saturating 2-bit counter");
        step(1, 1'b1, 1'b0, 1'b0, 3, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b0);
            if (i > 0) checkOutput("sat_cnt", int'(cnt2), CNT_EN ? exp36[i] : 0);
        end
        step(1, 1'b0, 1'b1, 1'b1, 0, 1'b1, 1'b1);
        checkOutput("sat_clr_y", int'(y2), 1);
        checkOutput("sat_clr_cnt", int'(cnt2), 0);

        resetAsync("r5");
        $display("[TB] async reset mid-run");
        step(0, 1'b1, 1'b0, 1'b0, 9, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(0, 1'b0, 1'b1, 1'(s7[i]), 0, 1'b1, 1'b0);
        checkOutput("pre_rst_y", int'(y4), 1);
        resetAsync("r6");
        foreach (s7[i]) step(0, 1'b0, 1'b1, 1'(s7[i]), 0, 1'b1, 1'b0);
        checkOutput("noload_pulses", yCount[0], 0);

        $display("[TB] random traffic");
        for (int n = 0; n < 600; n++) begin
            idleAll();
            for (int d = 0; d < 2; d++) begin
                applyStimulus(d,
                              1'($urandom_range(19) == 0),
                              1'($urandom_range(3) != 0),
                              1'($urandom_range(1)),
                              int'($urandom_range((1 << mLen[d]) - 1)),
                              1'($urandom_range(1)),
                              1'($urandom_range(39) == 0));
            end
            tick();
            if (n % 200 == 150) resetAsync("rnd_rst");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
